// File: rtl/afu_io_pkg.sv
// Shared types and constants for the transpose AFU host-side I/O controller.
package afu_io_pkg;

  localparam int CL_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } afu_state_e;

  // Reads in flight plus lines already queued must stay below this, so every
  // returning response is guaranteed a free slot in the AFU input FIFO.
  function automatic logic [31:0] credit_limit(input int unsigned depth_bits);
    credit_limit = (32'd1 << depth_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/afu_io_ctrl_wr_stage_buf.sv
// Two-entry staging buffer between the synchronous-read AFU output FIFO and
// the memory write request port.
module wr_stage_buf
  import afu_io_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     re,
  input  logic [CL_DATA_WIDTH-1:0] din,
  input  logic                     ready,
  output logic                     valid,
  output logic [CL_DATA_WIDTH-1:0] data,
  output logic [1:0]               occ,
  output logic                     re_d
);

  logic [CL_DATA_WIDTH-1:0] entry [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic                     push;
  logic                     pop;

  assign push  = re_d;
  assign pop   = valid && ready;
  assign valid = (occ != 2'd0);
  // Masked so the port reads zero whenever nothing is staged, including reset.
  assign data  = valid ? entry[rd_ptr] : '0;

  // Stage 1: FIFO dout becomes valid one cycle after re
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      re_d   <= 1'b0;
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      re_d <= re;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // Stage 2: capture into the slot named by the write pointer
  always_ff @(posedge clk) begin
    if (push) entry[wr_ptr] <= din;
  end

endmodule

// File: rtl/afu_io_ctrl.sv
// Host-side I/O controller for the transpose AFU: streams source lines into the
// AFU input FIFO and drains transposed lines out to memory write requests.
module afu_io_ctrl
  import afu_io_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BUFF_DEPTH_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ctx_valid,
  input  logic [ADDR_WIDTH-1:0]      ctx_src_addr,
  input  logic [ADDR_WIDTH-1:0]      ctx_dst_addr,
  input  logic [31:0]                ctx_length,
  output logic [31:0]                ctx_length_o,
  output logic                       ctx_done,
  output logic                       ctx_err,
  output logic                       rd_req_valid,
  output logic [ADDR_WIDTH-1:0]      rd_req_addr,
  input  logic                       rd_req_ready,
  input  logic                       rd_rsp_valid,
  input  logic [CL_DATA_WIDTH-1:0]   rd_rsp_data,
  output logic [CL_DATA_WIDTH-1:0]   input_fifo_din,
  output logic                       input_fifo_we,
  input  logic                       input_fifo_full,
  input  logic [BUFF_DEPTH_BITS-1:0] input_fifo_count,
  input  logic [CL_DATA_WIDTH-1:0]   output_fifo_dout,
  output logic                       output_fifo_re,
  input  logic                       output_fifo_empty,
  output logic                       wr_req_valid,
  output logic [ADDR_WIDTH-1:0]      wr_req_addr,
  output logic [CL_DATA_WIDTH-1:0]   wr_req_data,
  input  logic                       wr_req_ready,
  input  logic                       wr_rsp_valid
);

  localparam logic [31:0] CREDITS = credit_limit(BUFF_DEPTH_BITS);

  afu_state_e            state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [31:0]           len;
  logic [31:0]           rd_issued;
  logic [31:0]           outstanding;
  logic [31:0]           wr_issued;
  logic [31:0]           wr_ack_cnt;

  logic                  running;
  logic                  start;
  logic                  rd_hs;
  logic                  rsp_acc;
  logic                  wr_hs;
  logic                  ack_inc;
  logic [1:0]            stage_occ;
  logic                  stage_re_d;
  logic [31:0]           in_count;
  logic [31:0]           staged;

  assign running  = (state == ST_RUN);
  // A start pulse is honoured from DONE as well, so back-to-back contexts
  // never need an idle cycle in between.
  assign start    = ctx_valid && !running;
  assign in_count = 32'(input_fifo_count);
  assign staged   = 32'(stage_occ) + 32'(stage_re_d);

  assign rd_req_valid = running && (rd_issued < len) && !input_fifo_full &&
                        ((outstanding + in_count) < CREDITS);
  assign rd_req_addr  = src + ADDR_WIDTH'(rd_issued);
  assign rd_hs        = rd_req_valid && rd_req_ready;

  assign input_fifo_we  = rd_rsp_valid && (outstanding != 32'd0);
  assign input_fifo_din = rd_rsp_data;
  assign rsp_acc        = input_fifo_we;

  // In-flight FIFO reads count against both buffer space and the line budget.
  assign output_fifo_re = running && !output_fifo_empty && (staged < 32'd2) &&
                          ((wr_issued + staged) < len);
  assign wr_req_addr    = dst + ADDR_WIDTH'(wr_issued);
  assign wr_hs          = wr_req_valid && wr_req_ready;

  assign ack_inc = running && wr_rsp_valid && (wr_ack_cnt < len);

  assign ctx_length_o = len;
  assign ctx_done     = (state == ST_DONE);

  wr_stage_buf u_wr_stage_buf (
    .clk   (clk),
    .reset (reset),
    .re    (output_fifo_re),
    .din   (output_fifo_dout),
    .ready (wr_req_ready),
    .valid (wr_req_valid),
    .data  (wr_req_data),
    .occ   (stage_occ),
    .re_d  (stage_re_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      rd_issued   <= '0;
      outstanding <= '0;
      wr_issued   <= '0;
      wr_ack_cnt  <= '0;
      ctx_err     <= 1'b0;
    end else begin
      if (rd_rsp_valid && (outstanding == 32'd0)) ctx_err <= 1'b1;

      if (start) begin
        src         <= ctx_src_addr;
        dst         <= ctx_dst_addr;
        len         <= ctx_length;
        rd_issued   <= '0;
        outstanding <= '0;
        wr_issued   <= '0;
        wr_ack_cnt  <= '0;
        state       <= (ctx_length != 32'd0) ? ST_RUN : ST_DONE;
      end else begin
        if (rd_hs) rd_issued <= rd_issued + 32'd1;

        if (rd_hs && !rsp_acc)      outstanding <= outstanding + 32'd1;
        else if (!rd_hs && rsp_acc) outstanding <= outstanding - 32'd1;

        if (wr_hs)   wr_issued  <= wr_issued + 32'd1;
        if (ack_inc) wr_ack_cnt <= wr_ack_cnt + 32'd1;

        // Compare against the post-increment count so DONE follows the final ack directly.
        if (running && ((wr_ack_cnt + 32'(ack_inc)) == len)) state <= ST_DONE;
      end
    end
  end

endmodule

// File: tb/tb_afu_io_ctrl.sv
// Transaction-level bench for afu_io_ctrl: memory, AFU datapath and write-ack
// models plus a scoreboard of expected read/write traffic.
module tb_afu_io_ctrl;

  localparam int AW  = 32;
  localparam int BDB = 3;
  localparam int CREDIT_CAP = (1 << BDB) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           ctx_valid;
  logic [AW-1:0]  ctx_src_addr;
  logic [AW-1:0]  ctx_dst_addr;
  logic [31:0]    ctx_length;
  logic [31:0]    ctx_length_o;
  logic           ctx_done;
  logic           ctx_err;
  logic           rd_req_valid;
  logic [AW-1:0]  rd_req_addr;
  logic           rd_req_ready;
  logic           rd_rsp_valid;
  logic [511:0]   rd_rsp_data;
  logic [511:0]   input_fifo_din;
  logic           input_fifo_we;
  logic           input_fifo_full;
  logic [BDB-1:0] input_fifo_count;
  logic [511:0]   output_fifo_dout;
  logic           output_fifo_re;
  logic           output_fifo_empty;
  logic           wr_req_valid;
  logic [AW-1:0]  wr_req_addr;
  logic [511:0]   wr_req_data;
  logic           wr_req_ready;
  logic           wr_rsp_valid;

  always #5 clk = ~clk;

  afu_io_ctrl #(.ADDR_WIDTH(AW), .BUFF_DEPTH_BITS(BDB)) dut (
    .clk(clk), .reset(reset), .ctx_valid(ctx_valid), .ctx_src_addr(ctx_src_addr),
    .ctx_dst_addr(ctx_dst_addr), .ctx_length(ctx_length), .ctx_length_o(ctx_length_o),
    .ctx_done(ctx_done), .ctx_err(ctx_err), .rd_req_valid(rd_req_valid),
    .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_data(rd_rsp_data), .input_fifo_din(input_fifo_din), .input_fifo_we(input_fifo_we),
    .input_fifo_full(input_fifo_full), .input_fifo_count(input_fifo_count),
    .output_fifo_dout(output_fifo_dout), .output_fifo_re(output_fifo_re),
    .output_fifo_empty(output_fifo_empty), .wr_req_valid(wr_req_valid),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_ready(wr_req_ready),
    .wr_rsp_valid(wr_rsp_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int           due;
    logic [511:0] data;
  } rsp_t;

  rsp_t         resp_q[$];
  logic [511:0] in_q[$];
  logic [511:0] out_q[$];
  int           ack_q[$];
  logic [511:0] dout_next;
  int           cyc = 0;
  bit           running, exp_done, exp_err;
  logic [31:0]  m_src, m_dst, m_len, rd_cnt, wr_cnt, acks;
  int           staged;
  int           rsp_lat_min, rsp_lat_max, ack_lat;
  bit           rd_rdy_rand, wr_rdy_rand, wr_stall, withhold, stray_now, start_now;
  logic [31:0]  seed;
  bit           prev_hold;
  logic [31:0]  prev_addr;
  logic [511:0] prev_data;

  function automatic logic [511:0] mem_line(input logic [31:0] a);
    logic [511:0] o;
    for (int k = 0; k < 16; k++) o[k*32 +: 32] = (a * 32'h9E3779B9) ^ (seed + 32'(k) * 32'h01000193);
    return o;
  endfunction

  // The AFU transposes by reversing the order of the sixteen 32-bit words.
  function automatic logic [511:0] xform(input logic [511:0] d);
    logic [511:0] o;
    for (int k = 0; k < 16; k++) o[k*32 +: 32] = d[(15-k)*32 +: 32];
    return o;
  endfunction

  task automatic model_reset();
    resp_q.delete(); in_q.delete(); out_q.delete(); ack_q.delete();
    dout_next = '0; running = 0; exp_done = 0; exp_err = 0;
    m_src = 0; m_dst = 0; m_len = 0; rd_cnt = 0; wr_cnt = 0; acks = 0;
    staged = 0; prev_hold = 0;
  endtask

  task automatic cycle();
    bit           stray;
    rsp_t         r;
    logic [31:0]  ea;
    @(negedge clk);
    ctx_valid    = start_now;
    rd_req_ready = rd_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_req_ready = wr_stall ? 1'b0 : (wr_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    stray = stray_now;
    if (stray) begin
      rd_rsp_valid = 1'b1; rd_rsp_data = {16{32'hDEADBEEF}};
    end else if (!withhold && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      rd_rsp_valid = 1'b1; rd_rsp_data = resp_q[0].data;
    end else begin
      rd_rsp_valid = 1'b0; rd_rsp_data = '0;
    end
    input_fifo_full   = (in_q.size() >= (1 << BDB));
    input_fifo_count  = BDB'(in_q.size());
    output_fifo_empty = (out_q.size() == 0);
    output_fifo_dout  = dout_next;
    wr_rsp_valid      = (ack_q.size() > 0 && ack_q[0] <= cyc);
    #1;
    check("ctx_done", ctx_done, exp_done);
    check("ctx_err", ctx_err, exp_err);
    check("ctx_length_o", ctx_length_o, m_len);
    check("rd_req_valid", rd_req_valid,
          running && (rd_cnt < m_len) && ((resp_q.size() + in_q.size()) < CREDIT_CAP));
    check("input_fifo_we", input_fifo_we, rd_rsp_valid && !stray);

    if (rd_rsp_valid && !stray) void'(resp_q.pop_front());
    if (rd_req_valid && rd_req_ready) begin
      ea = m_src + rd_cnt;
      check("rd_req_addr", rd_req_addr, ea);
      r.due  = cyc + $urandom_range(rsp_lat_min, rsp_lat_max);
      r.data = mem_line(ea);
      resp_q.push_back(r);
      rd_cnt++;
    end
    if (input_fifo_we) in_q.push_back(input_fifo_din);

    if (prev_hold) begin
      check("wr_hold_valid", wr_req_valid, 1'b1);
      check("wr_hold_addr", wr_req_addr, prev_addr);
      check("wr_hold_data", wr_req_data, prev_data);
    end
    prev_hold = wr_req_valid && !wr_req_ready;
    prev_addr = wr_req_addr;
    prev_data = wr_req_data;
    if (wr_req_valid && wr_req_ready) begin
      ea = m_dst + wr_cnt;
      check("wr_req_addr", wr_req_addr, ea);
      ea = m_src + wr_cnt;
      check("wr_req_data", wr_req_data, xform(mem_line(ea)));
      wr_cnt++; staged--;
      ack_q.push_back(cyc + ack_lat);
    end
    if (output_fifo_re) begin
      check("re_nonempty", out_q.size() != 0, 1'b1);
      check("re_within_len", (wr_cnt + 32'(staged)) < m_len, 1'b1);
      dout_next = (out_q.size() != 0) ? out_q.pop_front() : '0;
      staged++;
    end
    check("stage_occ", staged <= 2, 1'b1);

    if (wr_rsp_valid) begin
      void'(ack_q.pop_front());
      if (running) acks++;
    end
    if (running && acks == m_len) begin
      running = 0; exp_done = 1;
    end
    if (stray) exp_err = 1;
    if (ctx_valid && !running) begin
      m_src = ctx_src_addr; m_dst = ctx_dst_addr; m_len = ctx_length;
      rd_cnt = 0; wr_cnt = 0; acks = 0;
      running  = (ctx_length != 0);
      exp_done = (ctx_length == 0);
    end
    if (in_q.size() > 0 && out_q.size() < (1 << BDB)) out_q.push_back(xform(in_q.pop_front()));
    cyc++;
  endtask

  task automatic start_ctx(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    ctx_src_addr = s; ctx_dst_addr = d; ctx_length = l;
    start_now = 1; cycle(); start_now = 0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!exp_done && n < budget) begin cycle(); n++; end
    check({tag, "_complete"}, exp_done, 1'b1);
    check({tag, "_rd_count"}, rd_cnt, m_len);
    check({tag, "_wr_count"}, wr_cnt, m_len);
    repeat (3) cycle();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctx_length_o"}, ctx_length_o, '0);
    check({tag, "_ctx_done"}, ctx_done, '0);
    check({tag, "_ctx_err"}, ctx_err, '0);
    check({tag, "_rd_req_valid"}, rd_req_valid, '0);
    check({tag, "_rd_req_addr"}, rd_req_addr, '0);
    check({tag, "_input_fifo_din"}, input_fifo_din, '0);
    check({tag, "_input_fifo_we"}, input_fifo_we, '0);
    check({tag, "_output_fifo_re"}, output_fifo_re, '0);
    check({tag, "_wr_req_valid"}, wr_req_valid, '0);
    check({tag, "_wr_req_addr"}, wr_req_addr, '0);
    check({tag, "_wr_req_data"}, wr_req_data, '0);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b1;
    ctx_valid = 0; rd_req_ready = 0; rd_rsp_valid = 0; rd_rsp_data = '0;
    input_fifo_full = 0; input_fifo_count = '0; output_fifo_dout = '0;
    output_fifo_empty = 1; wr_req_ready = 0; wr_rsp_valid = 0;
    #1;
    check_outputs_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    ctx_src_addr = '0; ctx_dst_addr = '0; ctx_length = '0;
    rd_rdy_rand = 0; wr_rdy_rand = 0; wr_stall = 0; withhold = 0;
    stray_now = 0; start_now = 0;
    rsp_lat_min = 3; rsp_lat_max = 3; ack_lat = 1;
    seed = 32'h1234_5678;
    apply_reset("por");

    stray_now = 1; cycle(); stray_now = 0;
    cycle();
    check("stray_err", ctx_err, 1'b1);

    start_ctx(32'h40, 32'h80, 32'd0);
    cycle();
    check("len0_done", ctx_done, 1'b1);
    check("len0_no_reads", rd_cnt, 32'd0);

    start_ctx(32'h100, 32'h200, 32'd4);
    wait_done(200, "len4");

    withhold = 1;
    start_ctx(32'h1000, 32'h2000, 32'd16);
    repeat (30) cycle();
    check("credit_cap", rd_cnt, 32'(CREDIT_CAP));
    check("credit_stall", rd_req_valid, 1'b0);
    withhold = 0;
    wait_done(600, "len16");

    start_ctx(32'h3000, 32'h4000, 32'd12);
    for (int n = 0; n < 200 && wr_cnt < 3; n++) cycle();
    wr_stall = 1;
    repeat (10) cycle();
    check("stall_buffered", staged, 2);
    wr_stall = 0;
    wait_done(400, "stall");

    for (int k = 0; k < 4; k++) begin
      logic [31:0] s, d, l;
      rd_rdy_rand = 1; wr_rdy_rand = 1;
      rsp_lat_min = 1; rsp_lat_max = 6; ack_lat = $urandom_range(1, 4);
      seed = $urandom;
      l = $urandom_range(1, 20);
      s = (k == 0) ? 32'hFFFF_FFFA : $urandom;
      d = (k == 0) ? 32'hFFFF_FFFE : $urandom;
      start_ctx(s, d, l);
      if (k == 1) begin
        repeat (3) cycle();
        start_ctx(32'hABCD_0000, 32'h1234_0000, 32'd5);
      end
      wait_done(2000, "rand");
    end

    rd_rdy_rand = 0; wr_rdy_rand = 0; rsp_lat_min = 3; rsp_lat_max = 3; ack_lat = 1;
    start_ctx(32'h5000, 32'h6000, 32'd8);
    for (int n = 0; n < 100 && rd_cnt < 5; n++) cycle();
    check("mid_reads_before_reset", rd_cnt, 32'd5);
    apply_reset("mid");
    start_ctx(32'h7000, 32'h7100, 32'd8);
    wait_done(400, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
